dc_nbank_data_array: RTL

//  Parametrised L1 D-cache data array: NBANKS single-port banks x WAYS ways x SETS rows of 64-bit words.

---
 rtl/dc_databank_pkg.sv | 56 +++++
 rtl/dc_databank.sv | 37 +++
 rtl/dc_nbank_data_array.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dc_databank_pkg.sv
// Shared types and helpers for the n-bank D-cache data array: req_type field
// layout, access size encoding, the S1 pipeline record, byte masks and load formatting.
package dc_databank_pkg;

    localparam int unsigned TYPE_SIZE_LSB = 0;
    localparam int unsigned TYPE_SIZE_W   = 2;
    localparam int unsigned TYPE_SIGN_BIT = 2;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Fields are sized for the largest supported geometry; users zero-extend into them.
    localparam int unsigned S1_WAY_W  = 8;
    localparam int unsigned S1_ROW_W  = 16;
    localparam int unsigned S1_BANK_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [S1_WAY_W-1:0]  way;
        logic [S1_ROW_W-1:0]  row;
        logic [S1_BANK_W-1:0] bank;
        logic [2:0]           offset;
        size_e                size;
        logic                 sgn;
    } s1_rec_t;

    function automatic logic [7:0] byte_mask(input size_e size, input logic [2:0] off);
        logic [7:0] base;
        unique case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] load_format(input logic [63:0] word, input logic [2:0] off,
                                                input size_e size, input logic sgn);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {off, 3'b000};
        unique case (size)
            SZ_B:    res = sgn ? {{56{sh[7]}}, sh[7:0]}   : {56'd0, sh[7:0]};
            SZ_H:    res = sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
            SZ_W:    res = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dc_databank.sv
// One data bank: single-port synchronous SRAM of WAYS*SETS 64-bit words with
// per-byte write enable. Read data is registered and holds until the next read.
module dc_databank #(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 128,
    localparam int unsigned IDX_W = $clog2(WAYS) + $clog2(SETS),
    localparam int unsigned DEPTH = 2 ** IDX_W
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [7:0]       be_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 8; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dc_nbank_data_array.sv
// L1 D-cache data array: NBANKS banks, in-order load pipeline with a 2-entry ack skid buffer.
// Define DC_DATABANK_STATS_EN to add saturating access/retry counters and their output ports.
module dc_nbank_data_array
    import dc_databank_pkg::*;
#(
    parameter int unsigned NBANKS   = 4,
    parameter int unsigned WAYS     = 4,
    parameter int unsigned SETS     = 128,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 39,
    parameter int unsigned REQ_BITS = 7,
    localparam int unsigned WAY_W   = $clog2(WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_retry,
    input  logic                req_write,
    input  logic [REQ_BITS-1:0] req_type,
    input  logic [WAY_W-1:0]    req_way,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    output logic                ack_valid,
    input  logic                ack_retry,
    output logic [DATA_W-1:0]   ack_data
`ifdef DC_DATABANK_STATS_EN
    ,
    output logic [31:0]         stat_loads,
    output logic [31:0]         stat_stores,
    output logic [31:0]         stat_retry_cycles,
    output logic [31:0]         stat_bank_acc [NBANKS]
`endif
);

    localparam int unsigned BANK_W = $clog2(NBANKS);
    localparam int unsigned ROW_W  = $clog2(SETS);

    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [2:0]        req_off;
    size_e             req_size;
    logic              req_sgn;
    logic              accept;
    logic [NBANKS-1:0] bank_en;
    logic [7:0]        wr_be;
    logic [63:0]       wr_data;
    logic [63:0]       bank_rdata [NBANKS];
    logic [63:0]       rd_word;
    logic [63:0]       fmt_data;

    s1_rec_t     s1_q, s1_d;
    logic [63:0] buf_q [2];
    logic [63:0] buf_d [2];
    logic [1:0]  cnt_q, cnt_d;
    logic        push, pop;

    assign req_off  = req_addr[2:0];
    assign req_bank = req_addr[3 +: BANK_W];
    assign req_row  = req_addr[3 + BANK_W +: ROW_W];
    assign req_size = size_e'(req_type[TYPE_SIZE_LSB +: TYPE_SIZE_W]);
    assign req_sgn  = req_type[TYPE_SIGN_BIT];

    // Stores are held off too, so a store never overtakes the retry decision for a load.
    assign req_retry = ({1'b0, s1_q.valid} + cnt_q) >= 2'd2;
    assign accept    = req_valid && !req_retry;

    assign wr_be   = byte_mask(req_size, req_off);
    assign wr_data = req_data << {req_off, 3'b000};

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        assign bank_en[b] = accept && (req_bank == BANK_W'(b));

        dc_databank #(
            .WAYS (WAYS),
            .SETS (SETS)
        ) u_bank (
            .clk_i   (clk),
            .en_i    (bank_en[b]),
            .we_i    (req_write),
            .be_i    (wr_be),
            .addr_i  ({req_way, req_row}),
            .wdata_i (wr_data),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        s1_d        = '0;
        s1_d.valid  = accept && !req_write;
        s1_d.way    = S1_WAY_W'(req_way);
        s1_d.row    = S1_ROW_W'(req_row);
        s1_d.bank   = S1_BANK_W'(req_bank);
        s1_d.offset = req_off;
        s1_d.size   = req_size;
        s1_d.sgn    = req_sgn;
    end

    assign rd_word  = bank_rdata[s1_q.bank[BANK_W-1:0]];
    assign fmt_data = load_format(rd_word, s1_q.offset, s1_q.size, s1_q.sgn);

    assign ack_valid = cnt_q != 2'd0;
    assign ack_data  = buf_q[0];
    assign push      = s1_q.valid;
    assign pop       = ack_valid && !ack_retry;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) buf_d[0] = fmt_data;
                else               buf_d[1] = fmt_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf_d[0] = buf_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf_d[0] = fmt_data;
                end else begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = fmt_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            cnt_q    <= 2'd0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            s1_q  <= s1_d;
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{req_addr, req_type, s1_q.way, s1_q.row, s1_q.bank};

`ifdef DC_DATABANK_STATS_EN
    logic [31:0] st_loads_q, st_loads_d;
    logic [31:0] st_stores_q, st_stores_d;
    logic [31:0] st_retry_q, st_retry_d;
    logic [31:0] st_bank_q [NBANKS];
    logic [31:0] st_bank_d [NBANKS];

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != '1) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        st_loads_d  = sat_inc(st_loads_q, accept && !req_write);
        st_stores_d = sat_inc(st_stores_q, accept && req_write);
        st_retry_d  = sat_inc(st_retry_q, req_valid && req_retry);
        for (int b = 0; b < NBANKS; b++) begin
            st_bank_d[b] = sat_inc(st_bank_q[b], bank_en[b]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_loads_q  <= '0;
            st_stores_q <= '0;
            st_retry_q  <= '0;
            for (int b = 0; b < NBANKS; b++) st_bank_q[b] <= '0;
        end else begin
            st_loads_q  <= st_loads_d;
            st_stores_q <= st_stores_d;
            st_retry_q  <= st_retry_d;
            st_bank_q   <= st_bank_d;
        end
    end

    assign stat_loads        = st_loads_q;
    assign stat_stores       = st_stores_q;
    assign stat_retry_cycles = st_retry_q;
    assign stat_bank_acc     = st_bank_q;
`endif

endmodule
